if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Fetch stage directly downstream of the PC register.
- Takes the current fetch PC each cycle and issues it to the I-cache. Collects in-order instruction responses into a small FIFO and presents PC/instruction pairs to decode with a valid/ready handshake.
- Generates the hold request that freezes the PC register when the queue cannot accept another fetch.
- Discards stale in-flight responses after a flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUT, 2, max outstanding I-cache requests; at most DEPTH.
- RESET_PC, 32'hBFC0_0000, PC value reported in empty/reset state.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  exception/branch-mispredict flush; kills queue and in-flight responses
- pc  in  32  fetch address from PC register
- pc_ce  in  1  PC register enable; no fetch issued when 0
- fetch_hold  out  1  to PC register: hold PC this cycle
- ic_req  out  1  I-cache request valid
- ic_addr  out  32  I-cache request address (equals pc)
- ic_ack  in  1  I-cache accepts request this cycle
- ic_rvalid  in  1  I-cache response valid (responses in request order)
- ic_rdata  in  32  instruction word
- id_valid  out  1  decode entry valid
- id_pc  out  32  PC of head entry
- id_inst  out  32  instruction of head entry
- id_ready  in  1  decode consumes head entry
- empty  out  1  queue empty and nothing outstanding

Behaviour:
- Reset values:
  - id_valid=0, ic_req=0, fetch_hold=1, empty=1.
  - id_pc=RESET_PC, id_inst=0.
  - Counters (occupancy, outstanding, drop) = 0.
- Slot reservation:
  - credits = DEPTH - occupancy - outstanding.
  - ic_req = pc_ce & ~flush & ~rst & (credits>0) & (outstanding<MAX_OUT).
  - All comparisons unsigned, counters clog2(DEPTH)+1 bits wide.
- Issue:
  - Issue fires when ic_req & ic_ack. The PC of an issued request is pushed into a PC-tag FIFO (depth MAX_OUT), and outstanding increments.
  - fetch_hold = ~(ic_req & ic_ack). The PC register advances only on a fired issue.
- Response:
  - On ic_rvalid with drop==0: pop the PC-tag FIFO, write {pc_tag, ic_rdata} into the queue tail, occupancy+1, outstanding-1.
  - On ic_rvalid with drop>0: response discarded, drop-1, no queue write.
  - A fired issue and a response in the same cycle leave outstanding unchanged.
- Output:
  - id_valid = occupancy>0. id_pc/id_inst are driven combinationally from the head entry.
  - Pop on id_valid & id_ready. Push and pop in the same cycle is allowed, including when full; occupancy is unchanged.
  - When empty, id_pc=RESET_PC and id_inst=0.
- Zero-bubble path: not required. Response-to-id_valid latency is 1 cycle (registered write into the queue).
- Flush (highest priority, single cycle):
  - Occupancy is cleared and head/tail pointers are reset.
  - drop = outstanding minus responses arriving this cycle. outstanding=0, PC-tag FIFO cleared.
  - No issue in the flush cycle (ic_req=0). A response arriving in the flush cycle is discarded.
  - id_valid=0 the following cycle.
- While drop>0, new issues are allowed. Since responses are in order, the first drop responses are stale.
- credits counts drop entries as occupied. This prevents overflow of I-cache return slots.
- Pointer wrap: head/tail wrap modulo DEPTH. The full condition comes from the occupancy counter, not from pointer equality.
- empty = (occupancy==0)&(outstanding==0)&(drop==0).
- Protocol violations:
  - An ic_rvalid with outstanding==0 and drop==0 is ignored.
  - Assertions in simulation flag: this stray response; occupancy>DEPTH; outstanding>MAX_OUT.
- rst during operation overrides flush and clears all state on the next edge.

Test Plan:
- Reset, pc_ce=1, pc=0xBFC00000, ic_ack=1, responses 1 cycle later with rdata=0x24080001, id_ready=1 -> ic_req in the first cycle after reset; id_valid with id_pc=0xBFC00000, id_inst=0x24080001 two cycles after issue; steady-state throughput 1 instr/cycle, fetch_hold=0.
- id_ready=0 with back-to-back responses -> occupancy reaches 4, ic_req=0, fetch_hold=1, PC frozen; one id_ready pulse frees a slot and issue resumes the next cycle.
- Two requests outstanding (pc 0x100, 0x104), flush asserted, then both responses return -> both dropped, id_valid stays 0. A new fetch at 0x80000180 is delivered with the correct tag.
- Flush in the same cycle as a response and an id pop -> response dropped, occupancy=0, drop=outstanding-1, no spurious id_valid.
- ic_ack held 0 for 5 cycles -> ic_addr stable, fetch_hold=1 throughout, no tag pushed.
- Wrap test: 20 sequential instructions with random id_ready -> id_pc strictly sequential 0x0..0x4C with no loss or duplication.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Fetch queue sitting between the PC register and decode.
// Issues the current PC to the I-cache when a return slot can be reserved,
// tags each request with its PC, collects in-order responses into a small
// FIFO and hands PC/instruction pairs to decode on a valid/ready handshake.
// After a flush, responses still in flight are counted in 'drop' and
// discarded as they return, so they never reach decode.

module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic        pc_ce,
  output logic        fetch_hold,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic        ic_rvalid,
  input  logic [31:0] ic_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUT - 1);

  // Counters: entries held, live requests in flight, stale requests in flight.
  logic [CW-1:0] occ, occ_nxt;
  logic [CW-1:0] outs, outs_nxt;
  logic [CW-1:0] drop, drop_nxt;

  // Entry queue pointers; wrap naturally modulo DEPTH.
  logic [AW-1:0] head, head_nxt;
  logic [AW-1:0] tail, tail_nxt;

  // PC tag FIFO pointers; wrap explicitly so MAX_OUT need not be a power of two.
  logic [TW-1:0] tag_rd, tag_rd_nxt;
  logic [TW-1:0] tag_wr, tag_wr_nxt;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [31:0] tag_mem [MAX_OUT];

  logic [CW:0] used;
  logic        credit_ok;
  logic        issue;
  logic        rsp_any;
  logic        rsp_stale;
  logic        rsp_live;
  logic        push;
  logic        pop;

  // Slot reservation and handshake decode. Stale requests still hold a
  // return slot, so they count against the credits.
  always_comb begin
    used      = {1'b0, occ} + {1'b0, outs} + {1'b0, drop};
    credit_ok = (used < DEPTH_W);
    ic_req    = pc_ce & ~flush & ~rst & credit_ok & (outs < MAX_OUT_C);
    issue     = ic_req & ic_ack;
    rsp_stale = ic_rvalid & (drop != '0);
    rsp_live  = ic_rvalid & (drop == '0) & (outs != '0);
    rsp_any   = rsp_stale | rsp_live;
    push      = rsp_live & ~flush;
    pop       = id_valid & id_ready & ~flush;
  end

  // Next-state for counters and pointers; flush clears the queue and turns
  // everything still in flight into responses to drop.
  always_comb begin
    occ_nxt    = occ;
    outs_nxt   = outs;
    drop_nxt   = drop;
    head_nxt   = head;
    tail_nxt   = tail;
    tag_rd_nxt = tag_rd;
    tag_wr_nxt = tag_wr;
    if (flush) begin
      occ_nxt    = '0;
      outs_nxt   = '0;
      drop_nxt   = drop + outs - CW'(rsp_any);
      head_nxt   = '0;
      tail_nxt   = '0;
      tag_rd_nxt = '0;
      tag_wr_nxt = '0;
    end else begin
      occ_nxt  = occ + CW'(push) - CW'(pop);
      outs_nxt = outs + CW'(issue) - CW'(rsp_live);
      drop_nxt = drop - CW'(rsp_stale);
      if (push) tail_nxt = tail + AW'(1);
      if (pop)  head_nxt = head + AW'(1);
      if (rsp_live) tag_rd_nxt = (tag_rd == TAG_LAST) ? '0 : tag_rd + TW'(1);
      if (issue)    tag_wr_nxt = (tag_wr == TAG_LAST) ? '0 : tag_wr + TW'(1);
    end
  end

  // Control state register; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      outs   <= '0;
      drop   <= '0;
      head   <= '0;
      tail   <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      occ    <= occ_nxt;
      outs   <= outs_nxt;
      drop   <= drop_nxt;
      head   <= head_nxt;
      tail   <= tail_nxt;
      tag_rd <= tag_rd_nxt;
      tag_wr <= tag_wr_nxt;
    end
  end

  // Remember the PC of every accepted request until its response returns.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr] <= pc;
  end

  // Write a live response, paired with its tag, into the queue tail.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= tag_mem[tag_rd];
      q_inst[tail] <= ic_rdata;
    end
  end

  // Decode-facing outputs come straight from the head entry.
  always_comb begin
    id_valid   = (occ != '0);
    id_pc      = id_valid ? q_pc[head]   : RESET_PC;
    id_inst    = id_valid ? q_inst[head] : 32'h0;
    fetch_hold = ~issue;
    ic_addr    = pc;
    empty      = (occ == '0) & (outs == '0) & (drop == '0);
  end

`ifndef SYNTHESIS
  // Protocol and bookkeeping sanity checks.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(ic_rvalid && outs == '0 && drop == '0));
      assert (occ <= CW'(DEPTH));
      assert (outs <= MAX_OUT_C);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: transaction-level model (decode queue of
// PC/instruction pairs, in-flight request list with stale marks) compared
// against the DUT every cycle, plus directed scenarios with literal values.

module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, flush, pc_ce, ic_ack, ic_rvalid, id_ready;
  logic [31:0] pc, ic_rdata;
  logic        fetch_hold, ic_req, id_valid, empty;
  logic [31:0] ic_addr, id_pc, id_inst;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pc(pc), .pc_ce(pc_ce),
    .fetch_hold(fetch_hold), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ack(ic_ack), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ready(id_ready), .empty(empty)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; int icyc; } fl_t;

  ent_t dq[$];
  fl_t  inflight[$];
  logic [31:0] popped[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit k_rst, k_flush, k_ce, k_ack, k_rdy, k_rsp;
  bit fix_data, chk_en, rec_en;
  logic [31:0] pc_reg, k_target, fix_rdata;
  bit e_req, e_issue, e_vld, e_empty, did_rsp;
  logic [31:0] e_pc, e_inst, rsp_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic set(input bit r, input bit f, input bit ce, input bit ack, input bit rdy, input bit rsp);
    k_rst = r; k_flush = f; k_ce = ce; k_ack = ack; k_rdy = rdy; k_rsp = rsp;
  endtask

  // Drive this cycle's inputs, derive expectations from the model, compare.
  task automatic drive_check();
    int live;
    int used;
    rst = k_rst; flush = k_flush; pc = pc_reg; pc_ce = k_ce;
    ic_ack = k_ack; id_ready = k_rdy;
    did_rsp  = k_rsp && inflight.size() > 0 && inflight[0].icyc < cyc;
    rsp_data = fix_data ? fix_rdata : $urandom;
    ic_rvalid = did_rsp;
    ic_rdata  = rsp_data;
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    used    = dq.size() + inflight.size();
    e_req   = k_ce && !k_flush && !k_rst && used < DEPTH && live < MAX_OUT;
    e_issue = e_req && k_ack;
    e_vld   = dq.size() > 0;
    e_pc    = e_vld ? dq[0].pc : RESET_PC;
    e_inst  = e_vld ? dq[0].inst : 32'h0;
    e_empty = (used == 0);
    if (chk_en) begin
      chk("ic_req",     32'(ic_req),     32'(e_req));
      chk("fetch_hold", 32'(fetch_hold), 32'(!e_issue));
      chk("ic_addr",    ic_addr,         pc_reg);
      chk("id_valid",   32'(id_valid),   32'(e_vld));
      chk("id_pc",      id_pc,           e_pc);
      chk("id_inst",    id_inst,         e_inst);
      chk("empty",      32'(empty),      32'(e_empty));
    end
    if (rec_en && id_valid && id_ready) popped.push_back(id_pc);
  endtask

  // Clock edge: apply the cycle's effects to the model.
  task automatic advance();
    fl_t  f;
    ent_t e;
    @(posedge clk);
    if (k_rst) begin
      dq.delete();
      inflight.delete();
    end else begin
      if (e_vld && k_rdy) e = dq.pop_front();
      if (did_rsp) begin
        f = inflight.pop_front();
        if (!f.stale && !k_flush) begin
          e.pc = f.pc; e.inst = rsp_data;
          dq.push_back(e);
        end
      end
      if (k_flush) begin
        dq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
      end else if (e_issue) begin
        f.pc = pc_reg; f.stale = 1'b0; f.icyc = cyc;
        inflight.push_back(f);
      end
    end
    if (k_rst)        pc_reg = RESET_PC;
    else if (k_flush) pc_reg = k_target;
    else if (e_issue) pc_reg = pc_reg + 32'd4;
    cyc++;
    #1;
  endtask

  task automatic drain();
    set(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 40 && (dq.size() + inflight.size()) > 0; i++) begin
      drive_check(); advance();
    end
    drive_check();
    chk("drain_empty", 32'(empty), 32'd1);
    advance();
  endtask

  initial begin
    pc_reg = RESET_PC; k_target = '0; fix_rdata = '0;
    fix_data = 0; chk_en = 0; rec_en = 0;
    #1;

    // Reset
    set(1, 0, 1, 1, 0, 0);
    drive_check(); advance();
    chk_en = 1;
    drive_check();
    chk("rst_id_valid",   32'(id_valid),   32'd0);
    chk("rst_ic_req",     32'(ic_req),     32'd0);
    chk("rst_fetch_hold", 32'(fetch_hold), 32'd1);
    chk("rst_empty",      32'(empty),      32'd1);
    chk("rst_id_pc",      id_pc,           32'hBFC0_0000);
    chk("rst_id_inst",    id_inst,         32'h0);
    advance();

    // Basic stream, 1 instr/cycle
    pc_reg = 32'hBFC0_0000; fix_data = 1; fix_rdata = 32'h2408_0001;
    set(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      drive_check();
      if (i == 0) begin
        chk("first_req",  32'(ic_req), 32'd1);
        chk("first_addr", ic_addr,     32'hBFC0_0000);
      end
      if (i == 2) begin
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc",    id_pc,         32'hBFC0_0000);
        chk("first_inst",  id_inst,       32'h2408_0001);
      end
      if (i == 5) begin
        chk("steady_hold", 32'(fetch_hold), 32'd0);
        chk("steady_pc",   id_pc,           32'hBFC0_000C);
      end
      advance();
    end

    // Decode stalls: queue fills and fetch holds
    set(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin drive_check(); advance(); end
    drive_check();
    chk("full_req",   32'(ic_req),     32'd0);
    chk("full_hold",  32'(fetch_hold), 32'd1);
    chk("full_valid", 32'(id_valid),   32'd1);
    advance();
    set(0, 0, 1, 1, 1, 1);
    drive_check(); advance();
    set(0, 0, 1, 1, 0, 1);
    drive_check();
    chk("resume_req", 32'(ic_req), 32'd1);
    advance();
    fix_data = 0;
    drain();

    // Flush with two requests outstanding
    pc_reg = 32'h0000_0100;
    set(0, 0, 1, 1, 1, 0);
    drive_check(); advance();
    drive_check(); advance();
    k_target = 32'h8000_0180;
    set(0, 1, 1, 1, 1, 0);
    drive_check();
    chk("flush_req", 32'(ic_req), 32'd0);
    advance();
    set(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      drive_check();
      if (i < 3) chk("drop_valid", 32'(id_valid), 32'd0);
      if (i == 3) begin
        chk("refetch_valid", 32'(id_valid), 32'd1);
        chk("refetch_pc",    id_pc,         32'h8000_0180);
      end
      advance();
    end
    drain();

    // Flush coinciding with a response and a pop
    pc_reg = 32'h0000_0200;
    set(0, 0, 1, 1, 0, 0);
    drive_check(); advance();
    drive_check(); advance();
    set(0, 0, 0, 1, 0, 1);
    drive_check(); advance();
    set(0, 0, 1, 1, 0, 0);
    drive_check(); advance();
    k_target = 32'h0000_0400;
    set(0, 1, 0, 1, 1, 1);
    drive_check(); advance();
    set(0, 0, 0, 1, 1, 0);
    drive_check();
    chk("fl3_valid", 32'(id_valid), 32'd0);
    chk("fl3_empty", 32'(empty),    32'd0);
    advance();
    set(0, 0, 0, 1, 1, 1);
    drive_check(); advance();
    drive_check();
    chk("fl3_drained", 32'(empty), 32'd1);
    advance();
    drain();

    // I-cache refuses for 5 cycles
    pc_reg = 32'h0000_0300;
    set(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive_check();
      chk("nack_req",  32'(ic_req),     32'd1);
      chk("nack_addr", ic_addr,         32'h0000_0300);
      chk("nack_hold", 32'(fetch_hold), 32'd1);
      advance();
    end
    set(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive_check();
      if (i == 2) begin
        chk("nack_valid", 32'(id_valid), 32'd1);
        chk("nack_pc",    id_pc,         32'h0000_0300);
      end
      advance();
    end
    drain();

    // Pointer wrap: 20 sequential fetches, random decode/response timing
    pc_reg = 32'h0; rec_en = 1; popped.delete();
    for (int i = 0; i < 400 && popped.size() < 20; i++) begin
      set(0, 0, pc_reg < 32'h50, 1, 1'($urandom % 2), 1'($urandom % 2));
      drive_check(); advance();
    end
    rec_en = 0;
    chk("wrap_count", 32'(popped.size()), 32'd20);
    for (int i = 0; i < popped.size(); i++) chk("wrap_pc", popped[i], 32'(i * 4));
    drain();

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      k_target = $urandom & 32'hFFFF_FFFC;
      set(($urandom % 300) == 0, ($urandom % 20) == 0, ($urandom % 8) != 0,
          ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 5) < 3);
      drive_check(); advance();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
